// File: rtl/mem_responder_pkg.sv
// Shared types for the block-memory responder: command encoding, tag/block/address types and the response pipeline entry.
// Tag width is fixed by NUM_MEM_TAGS; instances may use fewer tags but never more.
package mem_responder_pkg;

  localparam int NUM_MEM_TAGS = 15;
  localparam int TAG_W        = 4;

  typedef logic [TAG_W-1:0] MEM_TAG;
  typedef logic [63:0]      MEM_BLOCK;
  typedef logic [31:0]      ADDR;

  typedef enum logic [1:0] {
    MEM_NONE  = 2'd0,
    MEM_LOAD  = 2'd1,
    MEM_STORE = 2'd2
  } MEM_COMMAND;

  typedef struct packed {
    logic     valid;
    MEM_TAG   tag;
    MEM_BLOCK data;
  } MEM_RESP_T;

  // Byte address to block index relative to the mapped base; addresses below base wrap high.
  function automatic ADDR block_of(input ADDR addr, input ADDR base);
    return (addr - base) >> 3;
  endfunction

endpackage

// File: rtl/mem_tag_allocator.sv
// Tag pool: combinational lowest-free grant in the request cycle; frees land after the edge.
// No backpressure beyond returning tag 0 when the pool is empty or no request is made.
module mem_tag_allocator
  import mem_responder_pkg::*;
#(
  parameter int NUM_TAGS = NUM_MEM_TAGS
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   alloc_req,
  output MEM_TAG alloc_tag,
  input  logic   free_vld,
  input  MEM_TAG free_tag
);

  logic [NUM_TAGS:1] free_mask;

  // Walk downwards so the last hit is the lowest-numbered free tag.
  always_comb begin
    alloc_tag = '0;
    if (alloc_req) begin
      for (int i = NUM_TAGS; i >= 1; i--) begin
        if (free_mask[i]) alloc_tag = MEM_TAG'(i);
      end
    end
  end

  // A tag being freed is still busy this cycle, so grant and free never hit the same bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      free_mask <= '1;
    end else begin
      for (int i = 1; i <= NUM_TAGS; i++) begin
        if (alloc_tag == MEM_TAG'(i)) free_mask[i] <= 1'b0;
        if (free_vld && free_tag == MEM_TAG'(i)) free_mask[i] <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Block memory responder: tags loads, returns snapshot data exactly LATENCY cycles after acceptance.
// Loads are refused (tag 0) under throttle or when no tag is free; the initiator must reissue.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int  NUM_TAGS     = NUM_MEM_TAGS,
  parameter int  LATENCY      = 4,
  parameter int  DEPTH_BLOCKS = 4096,
  parameter ADDR BASE_ADDR    = 32'h0
) (
  input  logic                             clk,
  input  logic                             rst,
  input  MEM_COMMAND                       proc2mem_command,
  input  ADDR                              proc2mem_addr,
  input  MEM_BLOCK                         proc2mem_data,
  input  logic                             throttle,
  input  logic                             init_we,
  input  logic [$clog2(DEPTH_BLOCKS)-1:0]  init_idx,
  input  MEM_BLOCK                         init_data,
  output MEM_TAG                           mem2proc_transaction_tag,
  output MEM_BLOCK                         mem2proc_data,
  output MEM_TAG                           mem2proc_data_tag,
  output logic [$clog2(NUM_TAGS+1)-1:0]    outstanding,
  output logic                             addr_err
);

  localparam int IDX_W = $clog2(DEPTH_BLOCKS);
  localparam int OUT_W = $clog2(NUM_TAGS + 1);

  if (LATENCY < 1 || LATENCY > NUM_TAGS) begin : g_bad_latency
    $error("mem_responder: LATENCY must be within 1..NUM_TAGS");
  end
  if (NUM_TAGS < 1 || NUM_TAGS > NUM_MEM_TAGS) begin : g_bad_tags
    $error("mem_responder: NUM_TAGS must be within 1..NUM_MEM_TAGS");
  end

  ADDR              blk;
  logic             in_range;
  logic [IDX_W-1:0] idx;
  logic             load_req;
  logic             accept;
  logic             store_ok;
  logic             resp_vld;

  MEM_BLOCK  mem  [DEPTH_BLOCKS];
  MEM_RESP_T pipe [LATENCY];

  assign blk      = block_of(proc2mem_addr, BASE_ADDR);
  assign in_range = blk < ADDR'(DEPTH_BLOCKS);
  assign idx      = blk[IDX_W-1:0];
  assign load_req = (proc2mem_command == MEM_LOAD) && !throttle;
  assign accept   = mem2proc_transaction_tag != '0;
  assign store_ok = (proc2mem_command == MEM_STORE) && in_range;
  assign resp_vld = pipe[LATENCY-1].valid;

  mem_tag_allocator #(.NUM_TAGS(NUM_TAGS)) u_alloc (
    .clk       (clk),
    .rst       (rst),
    .alloc_req (load_req),
    .alloc_tag (mem2proc_transaction_tag),
    .free_vld  (resp_vld),
    .free_tag  (pipe[LATENCY-1].tag)
  );

  // Store is written last so it wins over a coincident backdoor write.
  always_ff @(posedge clk) begin
    if (init_we)  mem[init_idx] <= init_data;
    if (store_ok) mem[idx]      <= proc2mem_data;
  end

  // Empty slots are held all-zero so the last stage drives the outputs directly.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LATENCY; i++) pipe[i] <= '0;
    end else begin
      if (accept)
        pipe[0] <= '{valid: 1'b1,
                     tag:   mem2proc_transaction_tag,
                     data:  in_range ? mem[idx] : '0};
      else
        pipe[0] <= '0;
      for (int i = 1; i < LATENCY; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign mem2proc_data     = pipe[LATENCY-1].data;
  assign mem2proc_data_tag = pipe[LATENCY-1].tag;

  always_ff @(posedge clk) begin
    if (rst) begin
      outstanding <= '0;
      addr_err    <= 1'b0;
    end else begin
      if (accept && !resp_vld)      outstanding <= outstanding + OUT_W'(1);
      else if (!accept && resp_vld) outstanding <= outstanding - OUT_W'(1);
      if ((accept || proc2mem_command == MEM_STORE) && !in_range) addr_err <= 1'b1;
    end
  end

endmodule
